// File: rtl/muldiv_pkg.sv
// Shared definitions for the multicycle MULT/DIV sequencer: state encoding,
// operation codes, iteration count, counter width and sign helpers.
package muldiv_pkg;

   localparam int ITER_N = 32;
   localparam int CNT_W  = $clog2(ITER_N) + 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   // Unsigned magnitude of a signed 32-bit value; the most negative value maps to 2^31.
   function automatic logic [31:0] mag32(input logic [31:0] v);
      return v[31] ? (32'd0 - v) : v;
   endfunction

   // Two's-complement negation when neg is set, pass-through otherwise.
   function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
      return neg ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/div_restore_step.sv
// One iteration of restoring division: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the result if it is
// non-negative and shift the matching quotient bit in.
module div_restore_step #(
   parameter int W = 32
) (
   input  logic [W:0]   rem_in,
   input  logic [W-1:0] quo_in,
   input  logic [W-1:0] divisor,
   output logic [W:0]   rem_out,
   output logic [W-1:0] quo_out
);

   logic [W+1:0] shifted_s;
   logic         fits_s;

   // Shift/trial-subtract; the remainder is restored by simply keeping the shifted value.
   always_comb begin
      shifted_s = {rem_in, quo_in[W-1]};
      fits_s    = (shifted_s >= {2'b00, divisor});
      if (fits_s) begin
         rem_out = (W+1)'(shifted_s - {2'b00, divisor});
         quo_out = {quo_in[W-2:0], 1'b1};
      end else begin
         rem_out = (W+1)'(shifted_s);
         quo_out = {quo_in[W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multicycle signed MULT (Booth radix-2) / DIV (restoring) engine, one iteration
// per clock. Optional feature macro: MULDIV_DIVZERO_CHECK_EN - when defined, a DIV
// by zero skips the iterations and finishes at once with div_zero raised.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic              div_zero,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   state_t              state_r, state_next_s;
   logic [CNT_W-1:0]    cnt_r;
   logic                op_r, qm1_r, neg_q_r, neg_r_r, dz_pend_r;
   // acc_r is the Booth A register in MULT and the partial remainder in DIV; the
   // extra top bit lets the most negative multiplicand be subtracted without overflow.
   logic [DATA_W:0]     acc_r;
   logic [DATA_W-1:0]   mq_r, mcand_r;
   logic                busy_r, done_r, div_zero_r;
   logic [DATA_W-1:0]   hi_r, lo_r;
   logic                last_iter_s, dz_start_s;
   logic [DATA_W:0]     booth_sum_s, rem_next_s;
   logic [DATA_W-1:0]   quo_next_s;

`ifdef MULDIV_DIVZERO_CHECK_EN
   assign dz_start_s = (op == OP_DIV) && (b == {DATA_W{1'b0}});
`else
   assign dz_start_s = 1'b0;
`endif

   assign last_iter_s = (cnt_r == CNT_W'(ITER_N - 1));

   div_restore_step #(.W(DATA_W)) u_div_step (
      .rem_in  (acc_r),
      .quo_in  (mq_r),
      .divisor (mcand_r),
      .rem_out (rem_next_s),
      .quo_out (quo_next_s)
   );

   // Booth add/subtract of the multiplicand selected by {Q0, q-1}.
   always_comb begin
      booth_sum_s = acc_r;
      case ({mq_r[0], qm1_r})
         2'b01:   booth_sum_s = acc_r + {mcand_r[DATA_W-1], mcand_r};
         2'b10:   booth_sum_s = acc_r - {mcand_r[DATA_W-1], mcand_r};
         default: booth_sum_s = acc_r;
      endcase
   end

   // Next-state logic: IDLE -> RUN (or FINISH for an early div-by-zero) -> FINISH -> IDLE.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               if (dz_start_s) begin
                  state_next_s = ST_FINISH;
               end else begin
                  state_next_s = ST_RUN;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_iter_s) begin
               state_next_s = ST_FINISH;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         ST_FINISH: state_next_s = ST_IDLE;
         default:   state_next_s = ST_IDLE;
      endcase
   end

   // State register, working registers, iteration datapath and registered results.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         cnt_r      <= {CNT_W{1'b0}};
         op_r       <= OP_MULT;
         qm1_r      <= 1'b0;
         neg_q_r    <= 1'b0;
         neg_r_r    <= 1'b0;
         dz_pend_r  <= 1'b0;
         acc_r      <= {(DATA_W+1){1'b0}};
         mq_r       <= {DATA_W{1'b0}};
         mcand_r    <= {DATA_W{1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         div_zero_r <= 1'b0;
         hi_r       <= {DATA_W{1'b0}};
         lo_r       <= {DATA_W{1'b0}};
      end else begin
         state_r <= state_next_s;
         busy_r  <= (state_next_s != ST_IDLE);
         done_r  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  cnt_r      <= {CNT_W{1'b0}};
                  op_r       <= op;
                  qm1_r      <= 1'b0;
                  acc_r      <= {(DATA_W+1){1'b0}};
                  div_zero_r <= 1'b0;
                  dz_pend_r  <= dz_start_s;
                  if (op == OP_MULT) begin
                     mq_r    <= b;
                     mcand_r <= a;
                     neg_q_r <= 1'b0;
                     neg_r_r <= 1'b0;
                  end else begin
                     mq_r    <= mag32(a);
                     mcand_r <= mag32(b);
                     neg_q_r <= a[DATA_W-1] ^ b[DATA_W-1];
                     neg_r_r <= a[DATA_W-1];
                  end
               end
            end
            ST_RUN: begin
               cnt_r <= cnt_r + CNT_W'(1);
               if (op_r == OP_MULT) begin
                  acc_r <= {booth_sum_s[DATA_W], booth_sum_s[DATA_W:1]};
                  mq_r  <= {booth_sum_s[0], mq_r[DATA_W-1:1]};
                  qm1_r <= mq_r[0];
               end else begin
                  acc_r <= rem_next_s;
                  mq_r  <= quo_next_s;
               end
            end
            ST_FINISH: begin
               done_r <= 1'b1;
               if (dz_pend_r) begin
                  div_zero_r <= 1'b1;
               end else if (op_r == OP_MULT) begin
                  hi_r <= acc_r[DATA_W-1:0];
                  lo_r <= mq_r;
               end else begin
                  hi_r <= cond_neg32(acc_r[DATA_W-1:0], neg_r_r);
                  lo_r <= cond_neg32(mq_r, neg_q_r);
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign div_zero = div_zero_r;
   assign hi       = hi_r;
   assign lo       = lo_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes hand-computed results
// with their expected completion cycle; a monitor pops and compares on each done.
// Honours MULDIV_DIVZERO_CHECK_EN for the divide-by-zero expectations.
module tb_muldiv_sequencer;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] model_hi = 32'd0;
   logic [31:0] model_lo = 32'd0;
   exp_t        sb[$];

   muldiv_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every done must match the oldest pending expectation.
   always @(negedge clk) begin
      exp_t e;
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending op", cyc);
         end else begin
            e = sb.pop_front();
            check({e.name, "_hi"}, hi, e.hi);
            check({e.name, "_lo"}, lo, e.lo);
            check({e.name, "_divzero"}, {31'd0, div_zero}, {31'd0, e.dz});
            check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
            check({e.name, "_busy_in_done"}, {31'd0, busy}, 32'd0);
         end
      end
   end

   // Call at a negedge; drives start for one edge and records the expectation.
   task automatic issue(input string name, input logic o, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [31:0] ehi,
                        input logic [31:0] elo, input logic edz, input int lat);
      exp_t e;
      e.name = name; e.hi = ehi; e.lo = elo; e.dz = edz; e.cyc = cyc + 1 + lat;
      sb.push_back(e);
      if (!edz) begin
         model_hi = ehi;
         model_lo = elo;
      end
      start = 1'b1; op = o; a = aa; b = bb;
      @(negedge clk);
      start = 1'b0; op = ~o; a = $urandom; b = $urandom;
      check({name, "_busy"}, {31'd0, busy}, 32'd1);
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: got %0d pending ops expected 0", name, sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_divzero", {31'd0, div_zero}, 32'd0);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);

      issue("mul_m3x5", 1'b0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33);
      wait_idle("mul_m3x5");
      issue("mul_minxmin", 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33);
      wait_idle("mul_minxmin");
      issue("mul_123456xm789", 1'b0, 32'd123456, 32'hFFFFFCEB, 32'hFFFFFFFF, 32'hFA31B0C0, 1'b0, 33);
      wait_idle("mul_123456xm789");

      issue("div_m7by2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
      wait_idle("div_m7by2");
      issue("div_minbym1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33);
      wait_idle("div_minbym1");
      issue("div_100bym7", 1'b1, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 1'b0, 33);
      wait_idle("div_100bym7");

`ifdef MULDIV_DIVZERO_CHECK_EN
      issue("div_7by0", 1'b1, 32'd7, 32'd0, model_hi, model_lo, 1'b1, 1);
`else
      issue("div_7by0", 1'b1, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 1'b0, 33);
`endif
      wait_idle("div_7by0");
      issue("mul_m1xm1", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b0, 33);
      wait_idle("mul_m1xm1");

      // start while busy must be ignored
      issue("mul_6x7", 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33);
      repeat (10) @(negedge clk);
      start = 1'b1; op = 1'b1; a = 32'd1; b = 32'd1;
      @(negedge clk);
      start = 1'b0;
      wait_idle("mul_6x7");
      repeat (40) @(negedge clk);

      // back-to-back: second start lands in the done cycle of the first
      issue("div_m100by7", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, 33);
      for (int i = 0; i < 100 && done !== 1'b1; i++) @(negedge clk);
      issue("mul_b2b", 1'b0, 32'h7FFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFE, 1'b0, 33);
      wait_idle("mul_b2b");

      // reset in the middle of RUN aborts without done
      issue("mul_aborted", 1'b0, 32'd1000, 32'd1000, 32'd0, 32'h000F4240, 1'b0, 33);
      repeat (13) @(negedge clk);
      sb.delete();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_hi = 32'd0;
      model_lo = 32'd0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      repeat (40) @(negedge clk);
      issue("div_100by7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
      wait_idle("div_100by7");

      repeat (40) @(negedge clk);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
